// File: rtl/fpga_robots_game_dump_tx_pkg.sv
// Shared encodings and constants for the tile-map dump transmitter.
// Also provides the nibble-to-ASCII helper used by the formatter.
package fpga_robots_game_dump_tx_pkg;

  typedef enum logic [2:0] {
    DTX_IDLE = 3'd0,
    DTX_HI   = 3'd1,
    DTX_LO   = 3'd2,
    DTX_CR   = 3'd3,
    DTX_LF   = 3'd4
  } dtx_state_e;

  localparam logic [7:0] ASC_CR = 8'h0D;
  localparam logic [7:0] ASC_LF = 8'h0A;

  localparam int DEFAULT_CLK_DIV        = 217;
  localparam int DEFAULT_BYTES_PER_LINE = 128;

  // Uppercase hex digit: 0..9 -> '0'..'9', 10..15 -> 'A'..'F'.
  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
  endfunction

endpackage

// File: rtl/fpga_robots_game_dump_tx_uart.sv
// 8N1 UART transmitter: start bit, 8 data bits LSB first, stop bit, CLK_DIV clocks per bit.
// Ready is raised on the last clock of the stop bit so frames can run back to back.
module uart_tx_8n1
  import fpga_robots_game_dump_tx_pkg::*;
#(
  parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] char,
  input  logic       char_valid,
  output logic       char_ready,
  output logic       txd
);

  localparam logic [15:0] BAUD_LAST = 16'(CLK_DIV - 1);

  logic        active_q, active_d;
  logic [15:0] baud_q, baud_d;
  logic [3:0]  bit_q, bit_d;
  logic [9:0]  shift_q, shift_d;
  logic        txd_q, txd_d;
  logic        bit_end;
  logic        frame_end;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    active_d = active_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;

    bit_end    = active_q && (baud_q == BAUD_LAST);
    frame_end  = bit_end && (bit_q == 4'd9);
    char_ready = !active_q || frame_end;

    if (char_valid && char_ready) begin
      active_d = 1'b1;
      baud_d   = '0;
      bit_d    = '0;
      shift_d  = {1'b1, char, 1'b0};
    end else if (frame_end) begin
      active_d = 1'b0;
    end else if (bit_end) begin
      baud_d  = '0;
      bit_d   = bit_q + 4'd1;
      shift_d = {1'b1, shift_q[9:1]};
    end else if (active_q) begin
      baud_d = baud_q + 16'd1;
    end

    // Line level is registered so txd never glitches; this adds the load cycle.
    txd_d = active_q ? shift_q[0] : 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= 1'b0;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '1;
      txd_q    <= 1'b1;
    end else begin
      active_q <= active_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      txd_q    <= txd_d;
    end
  end

  assign txd = txd_q;

endmodule

// File: rtl/fpga_robots_game_dump_tx.sv
// Dump back end: takes tile-map bytes, emits two uppercase hex digits per byte,
// inserts CR LF at line ends or on request, and serialises on an 8N1 line.
module fpga_robots_game_dump_tx
  import fpga_robots_game_dump_tx_pkg::*;
#(
  parameter int CLK_DIV        = DEFAULT_CLK_DIV,
  parameter int BYTES_PER_LINE = DEFAULT_BYTES_PER_LINE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_eol,
  output logic       in_ready,
  output logic       txd,
  output logic       busy
);

  localparam logic [7:0] COL_LAST = 8'(BYTES_PER_LINE - 1);

  dtx_state_e state_q, state_d;
  logic [7:0] data_q, data_d;
  logic       eol_q, eol_d;
  logic [7:0] col_q, col_d;

  logic [7:0] char;
  logic       char_send;
  logic       char_valid;
  logic       char_ready;

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    eol_d     = eol_q;
    col_d     = col_q;
    char      = 8'h00;
    char_send = 1'b0;

    in_ready = !rst && (state_q == DTX_IDLE) && char_ready;

    case (state_q)
      DTX_IDLE: begin
        if (in_valid && in_ready) begin
          data_d  = in_data;
          eol_d   = in_eol;
          state_d = DTX_HI;
        end
      end
      DTX_HI: begin
        char      = hex_ascii(data_q[7:4]);
        char_send = 1'b1;
        if (char_ready) state_d = DTX_LO;
      end
      DTX_LO: begin
        char      = hex_ascii(data_q[3:0]);
        char_send = 1'b1;
        if (char_ready) begin
          // A forced end of line at the column limit still yields a single CR LF.
          if (eol_q || (col_q == COL_LAST)) begin
            state_d = DTX_CR;
          end else begin
            col_d   = col_q + 8'd1;
            state_d = DTX_IDLE;
          end
        end
      end
      DTX_CR: begin
        char      = ASC_CR;
        char_send = 1'b1;
        if (char_ready) state_d = DTX_LF;
      end
      DTX_LF: begin
        char      = ASC_LF;
        char_send = 1'b1;
        if (char_ready) begin
          col_d   = 8'd0;
          state_d = DTX_IDLE;
        end
      end
      default: state_d = DTX_IDLE;
    endcase

    // Strobe only on the cycle the serializer takes the character.
    char_valid = char_send && char_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DTX_IDLE;
      data_q  <= 8'h00;
      eol_q   <= 1'b0;
      col_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      eol_q   <= eol_d;
      col_q   <= col_d;
    end
  end

  assign busy = (state_q != DTX_IDLE) || !char_ready;

  uart_tx_8n1 #(
    .CLK_DIV(CLK_DIV)
  ) u_uart (
    .clk       (clk),
    .rst       (rst),
    .char      (char),
    .char_valid(char_valid),
    .char_ready(char_ready),
    .txd       (txd)
  );

endmodule

// File: tb/tb_fpga_robots_game_dump_tx.sv
// Bench for the dump transmitter: table of bytes with expected text, a UART decoder
// scoreboard on txd, and hand sequences for latency, held valid and mid-frame reset.
module tb_fpga_robots_game_dump_tx;

  localparam int CLK_DIV = 4;
  localparam int BPL     = 2;
  localparam int FRAME   = 10 * CLK_DIV;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_eol;
  logic       in_ready;
  logic       txd;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;

  int cyc     = 0;
  int acc_cnt = 0;
  int acc_cyc = 0;

  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] data;
    logic       eol;
    string      text;
  } vec_t;

  vec_t vecs[10];

  fpga_robots_game_dump_tx #(
    .CLK_DIV       (CLK_DIV),
    .BYTES_PER_LINE(BPL)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .in_data (in_data),
    .in_valid(in_valid),
    .in_eol  (in_eol),
    .in_ready(in_ready),
    .txd     (txd),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    if (in_valid && in_ready) begin
      acc_cnt++;
      acc_cyc = cyc;
    end
  end

  // Line decoder: one sample per clock on the falling edge, FRAME samples per character.
  logic        dec_on = 1'b0;
  int          dec_i  = 0;
  logic [39:0] smp;
  logic        dec_ok;
  logic [7:0]  dec_ch;

  always @(negedge clk) begin
    if (rst) begin
      dec_on = 1'b0;
      dec_i  = 0;
    end else if (!dec_on) begin
      if (txd === 1'b0) begin
        dec_on = 1'b1;
        smp[0] = 1'b0;
        dec_i  = 1;
      end
    end else begin
      smp[dec_i] = txd;
      dec_i++;
      if (dec_i == FRAME) begin
        dec_on = 1'b0;
        dec_ok = (smp[36] === 1'b1);
        for (int b = 0; b < 10; b++)
          for (int s = 1; s < CLK_DIV; s++)
            if (smp[CLK_DIV*b+s] !== smp[CLK_DIV*b]) dec_ok = 1'b0;
        for (int b = 0; b < 8; b++) dec_ch[b] = smp[CLK_DIV*(b+1)];
        check("frame", dec_ok, 1);
        check("char_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("char", dec_ch, exp_q.pop_front());
      end
    end
  end

  task automatic push_text(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
  endtask

  // Offer one byte, return on the falling edge after it is accepted.
  task automatic send(input logic [7:0] d, input logic e, input string s);
    int n0;
    push_text(s);
    n0 = acc_cnt;
    @(negedge clk);
    in_data  = d;
    in_eol   = e;
    in_valid = 1'b1;
    for (int t = 0; t < 2000; t++) begin
      @(negedge clk);
      if (acc_cnt != n0) break;
    end
    in_valid = 1'b0;
    check("accept", acc_cnt - n0, 1);
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 5000; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) break;
    end
    check("drain_queue", exp_q.size(), 0);
    check("drain_busy", busy, 0);
  endtask

  initial begin
    int a, t1, t2, n0;

    vecs[0] = '{data: 8'h00, eol: 1'b0, text: "00\015\012"};
    vecs[1] = '{data: 8'hFF, eol: 1'b0, text: "FF"};
    vecs[2] = '{data: 8'h9A, eol: 1'b0, text: "9A\015\012"};
    vecs[3] = '{data: 8'h01, eol: 1'b0, text: "01"};
    vecs[4] = '{data: 8'h02, eol: 1'b0, text: "02\015\012"};
    vecs[5] = '{data: 8'h03, eol: 1'b0, text: "03"};
    vecs[6] = '{data: 8'h10, eol: 1'b1, text: "10\015\012"};
    vecs[7] = '{data: 8'h20, eol: 1'b0, text: "20"};
    vecs[8] = '{data: 8'h30, eol: 1'b0, text: "30\015\012"};
    vecs[9] = '{data: 8'h40, eol: 1'b1, text: "40\015\012"};

    rst      = 1'b1;
    in_data  = 8'h00;
    in_valid = 1'b0;
    in_eol   = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_txd", txd, 1);
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);

    // First byte at column 0: latency and return of in_ready
    send(8'hA5, 1'b0, "A5");
    a = acc_cyc;
    check("acc_in_ready", in_ready, 0);
    check("acc_busy", busy, 1);
    check("acc_txd", txd, 1);
    @(negedge clk);
    check("edge1_txd", txd, 1);
    @(negedge clk);
    check("edge2_txd_start", txd, 0);
    for (int t = 0; t < 1000; t++) begin
      if (in_ready) break;
      @(negedge clk);
    end
    check("in_ready_return", cyc - a, 20 * CLK_DIV);

    // Table: hex mapping, line limit and forced end of line
    foreach (vecs[i]) send(vecs[i].data, vecs[i].eol, vecs[i].text);
    wait_drain();

    // Held valid: the second byte must wait for in_ready, neither lost nor repeated
    push_text("11");
    push_text("22\015\012");
    n0 = acc_cnt;
    t1 = 0;
    t2 = 0;
    @(negedge clk);
    in_data  = 8'h11;
    in_eol   = 1'b0;
    in_valid = 1'b1;
    for (int t = 0; t < 2000; t++) begin
      @(negedge clk);
      if (acc_cnt == n0 + 1 && in_data == 8'h11) begin
        t1      = acc_cyc;
        in_data = 8'h22;
      end else if (acc_cnt == n0 + 2) begin
        t2       = acc_cyc;
        in_valid = 1'b0;
        break;
      end
    end
    in_valid = 1'b0;
    wait_drain();
    check("hold_accepts", acc_cnt - n0, 2);
    check("hold_spacing", t2 - t1, 20 * CLK_DIV + 1);

    // Reset during bit 3 of the first character
    send(8'h3C, 1'b0, "3C");
    a = acc_cyc;
    for (int t = 0; t < 100; t++) begin
      if (cyc >= a + 15) break;
      @(negedge clk);
    end
    #1 rst = 1'b1;
    @(negedge clk);
    exp_q.delete();
    check("midrst_txd", txd, 1);
    check("midrst_busy", busy, 0);
    check("midrst_in_ready", in_ready, 0);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_ready_after", in_ready, 1);
    // Column restarts at 0: the byte after 0x7E completes the line
    send(8'h7E, 1'b0, "7E");
    send(8'h01, 1'b0, "01\015\012");
    wait_drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
